uart_tx_arbiter: RTL and testbench

Message-granular round-robin arbiter that shares one `uart_tx` serializer among `N_REQ` byte-stream requesters. It sits between on-chip message sources (banner generator, status reporter, echo path) and the single `uart_tx` instance driving `uo_out[0]`. Each requester gets exclusive ownership for a whole message, delimited by `last`, so bytes from different sources never interleave on the line.

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 102 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake and uart_tx-side signals of the arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int PAYLOAD_BITS = 8
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] grant;
  logic [N_REQ*PAYLOAD_BITS-1:0] req_data;
  logic msg_abort;
  logic tx_en;
  logic tx_busy;
  logic [PAYLOAD_BITS-1:0] tx_data;
  modport slave (
    input req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, msg_abort, tx_en, tx_data
  );
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input req_ready, grant, msg_abort, tx_en, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one uart_tx among N_REQ byte streams
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int HOLD_TIMEOUT = 65535
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_d;
  logic [N_REQ-1:0] grant, grant_d;
  logic [IW-1:0] owner, owner_d, rr_ptr, rr_d, win, cand, nxt;
  logic [23:0] hold_cnt, hold_d;
  logic [PAYLOAD_BITS-1:0] tx_data, tx_data_d;
  logic last_r, last_d, tx_en, tx_en_d, abort, abort_d, found;
  assign nxt = owner == IW'(N_REQ - 1) ? '0 : owner + 1'b1;
  assign bus.req_ready = (state == SEND && !bus.tx_busy) ? grant & bus.req_valid : '0;
  assign bus.grant = grant;
  assign bus.tx_en = tx_en;
  assign bus.tx_data = tx_data;
  assign bus.msg_abort = abort;
  // round-robin search: walk down so the lowest offset from rr_ptr is written last and wins
  always_comb begin
    found = 1'b0;
    win = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IW'(({1'b0, rr_ptr} + (IW+1)'(k)) % (IW+1)'(N_REQ));
      if (bus.req_valid[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  // next-state and registered-output logic; tx_en defaults low so it is a one-cycle pulse
  always_comb begin
    state_d = state;
    grant_d = grant;
    owner_d = owner;
    rr_d = rr_ptr;
    hold_d = hold_cnt;
    last_d = last_r;
    tx_data_d = tx_data;
    tx_en_d = 1'b0;
    abort_d = 1'b0;
    case (state)
      IDLE: if (found) begin
        grant_d = N_REQ'(1) << win;
        owner_d = win;
        hold_d = '0;
        state_d = SEND;
      end
      SEND: if (bus.req_ready[owner]) begin
        tx_data_d = bus.req_data[owner*PAYLOAD_BITS +: PAYLOAD_BITS];
        tx_en_d = 1'b1;
        last_d = bus.req_last[owner];
        hold_d = '0;
        state_d = WAIT_HI;
      end else if (!bus.req_valid[owner] && !bus.tx_busy) begin
        if (hold_cnt == 24'(HOLD_TIMEOUT - 1)) begin
          grant_d = '0;
          rr_d = nxt;
          abort_d = 1'b1;
          state_d = IDLE;
        end else hold_d = hold_cnt + 1'b1;
      end
      WAIT_HI: state_d = bus.tx_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: if (!bus.tx_busy) begin
        state_d = last_r ? IDLE : SEND;
        grant_d = last_r ? '0 : grant;
        rr_d = last_r ? nxt : rr_ptr;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset discards any message in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      rr_ptr <= '0;
      hold_cnt <= '0;
      last_r <= 1'b0;
      tx_data <= '0;
      tx_en <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      owner <= owner_d;
      rr_ptr <= rr_d;
      hold_cnt <= hold_d;
      last_r <= last_d;
      tx_data <= tx_data_d;
      tx_en <= tx_en_d;
      abort <= abort_d;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of ordering, latency, timeout, busy and reset behaviour
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_force = 1'b0;
  logic busy_q = 1'b0;
  int busy_cnt = 0;
  int n_chk = 0;
  int n_err = 0;
  int viol = 0;
  int aborts = 0;
  int stall = 0;
  logic [W:0] q [N][$];
  logic [N+W-1:0] log_q [$];
  logic [N+W-1:0] exp_q [$];

  uart_tx_arbiter_if #(.N_REQ(N), .PAYLOAD_BITS(W)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .PAYLOAD_BITS(W), .HOLD_TIMEOUT(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  assign bus.tx_busy = busy_force | (busy_cnt != 0);

  // requesters present the head of their queue, changing only on the falling edge
  always @(negedge clk)
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = q[i].size() != 0;
      bus.req_data[i*W +: W] = q[i].size() != 0 ? q[i][0][W-1:0] : '0;
      bus.req_last[i] = q[i].size() != 0 && q[i][0][W];
    end

  // uart_tx stand-in (5 busy cycles per byte), byte log, and protocol watchers
  always @(posedge clk) begin
    busy_q <= bus.tx_busy;
    if (bus.tx_en) begin
      busy_cnt <= 5;
      log_q.push_back({bus.grant, bus.tx_data});
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if ((bus.tx_en && bus.tx_busy) || (bus.req_ready & ~bus.grant) != 0) viol <= viol + 1;
    if (bus.msg_abort) aborts <= aborts + 1;
    if (bus.grant != 0 && !bus.tx_busy && !busy_q && !bus.tx_en && bus.req_valid == 0) stall <= stall + 1;
    for (int i = 0; i < N; i++)
      if (bus.req_ready[i]) void'(q[i].pop_front());
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put(input int r, input logic [W-1:0] d, input logic l);
    q[r].push_back({l, d});
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(bus.grant == 0 && pending() == 0 && !bus.tx_busy) && n < 500);
    chk(tag, 32'(n < 500), 1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, ".n"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s.%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_tx_en", bus.tx_en, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_abort", bus.msg_abort, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    put(0, 8'h68, 0);
    put(0, 8'h69, 0);
    put(0, 8'h0D, 1);
    @(posedge clk);
    #1;
    chk("t1_grant", bus.grant, 4'b0001);
    chk("t1_ready", bus.req_ready, 4'b0001);
    @(posedge clk);
    #1;
    chk("t1_tx_en", bus.tx_en, 1);
    chk("t1_tx_data", bus.tx_data, 8'h68);
    @(posedge clk);
    #1;
    chk("t1_tx_en_drop", bus.tx_en, 0);
    wait_done("t1_done");
    exp_q = '{12'h168, 12'h169, 12'h10D};
    check_log("t1_log");
    chk("t1_rr", 32'(dut.rr_ptr), 1);
    put(1, 8'hA1, 0);
    put(1, 8'hA2, 1);
    put(2, 8'hB1, 0);
    put(2, 8'hB2, 1);
    wait_done("t2_done");
    exp_q = '{12'h2A1, 12'h2A2, 12'h4B1, 12'h4B2};
    check_log("t2_log");
    chk("t2_rr", 32'(dut.rr_ptr), 3);
    put(3, 8'hC1, 1);
    put(3, 8'hC2, 1);
    put(0, 8'hD1, 1);
    wait_done("t3_done");
    exp_q = '{12'h8C1, 12'h1D1, 12'h8C2};
    check_log("t3_log");
    chk("t3_rr", 32'(dut.rr_ptr), 0);
    stall = 0;
    aborts = 0;
    put(0, 8'hE1, 0);
    wait_done("t4_abort_done");
    repeat (2) @(posedge clk);
    #1;
    chk("t4_aborts", aborts, 1);
    chk("t4_stall_cycles", stall, 16);
    chk("t4_grant", bus.grant, 0);
    put(1, 8'hF1, 1);
    wait_done("t4_done");
    exp_q = '{12'h1E1, 12'h2F1};
    check_log("t4_log");
    busy_force = 1'b1;
    put(2, 8'h5A, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_grant", bus.grant, 4'b0100);
    chk("t5_ready_busy", bus.req_ready, 0);
    chk("t5_no_tx_en", log_q.size(), 0);
    @(negedge clk) busy_force = 1'b0;
    #1;
    chk("t5_ready_free", bus.req_ready, 4'b0100);
    @(posedge clk);
    #1;
    chk("t5_tx_en", bus.tx_en, 1);
    chk("t5_tx_data", bus.tx_data, 8'h5A);
    wait_done("t5_done");
    exp_q = '{12'h45A};
    check_log("t5_log");
    put(0, 8'h31, 0);
    put(0, 8'h32, 0);
    put(0, 8'h33, 1);
    for (int n = 0; n < 200 && log_q.size() < 2; n++) begin
      @(posedge clk);
      #1;
    end
    chk("t6_two_bytes", log_q.size(), 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_grant", bus.grant, 0);
    chk("t6_ready", bus.req_ready, 0);
    chk("t6_tx_en", bus.tx_en, 0);
    chk("t6_tx_data", bus.tx_data, 0);
    chk("t6_abort", bus.msg_abort, 0);
    chk("t6_rr", 32'(dut.rr_ptr), 0);
    q[0].delete();
    repeat (8) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    log_q.delete();
    @(posedge clk);
    #1;
    put(1, 8'h4A, 1);
    put(3, 8'h4B, 1);
    wait_done("t6_done");
    exp_q = '{12'h24A, 12'h84B};
    check_log("t6_log");
    chk("protocol_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
